// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Requester handshake and memory bus bundle for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req0;
  logic                  we0;
  logic [31:0]           addr0;
  logic [31:0]           wdata0;
  logic                  done0;
  logic [31:0]           rdata0;

  logic                  req1;
  logic                  we1;
  logic [31:0]           addr1;
  logic [31:0]           wdata1;
  logic                  done1;
  logic [31:0]           rdata1;

  logic                  busy;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  // The arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output done0, rdata0, done1, rdata1, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  // The environment side: requesters plus the memory itself
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  done0, rdata0, done1, rdata1, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin two-port arbiter/sequencer for a unified word memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam bit         NO_WAIT  = (MEM_LATENCY == 0);
  localparam logic [3:0] CNT_INIT = 4'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  last_gnt;
  logic                  gnt;
  logic                  win;
  logic                  any_req;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            cnt;
  logic [31:0]           rdata0_q;
  logic [31:0]           rdata1_q;
  logic [31:0]           cap_data;
  logic                  busy_c;
  logic                  mem_en_c;
  logic                  mem_we_c;
  logic                  done0_c;
  logic                  done1_c;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.addr0[31:ADDR_WIDTH+2], bus.addr0[1:0],
                              bus.addr1[31:ADDR_WIDTH+2], bus.addr1[1:0]};

  // On a tie the port that did not win last time gets the grant
  assign any_req  = bus.req0 | bus.req1;
  assign win      = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
  assign cap_data = lat_we ? 32'h0 : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (lat_we || NO_WAIT) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c   = (state != S_IDLE);
    mem_en_c = (state == S_ISSUE);
    mem_we_c = (state == S_ISSUE) && lat_we;
    done0_c  = (state == S_RESP) && !gnt;
    done1_c  = (state == S_RESP) &&  gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt  <= 1'b1;
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      cnt       <= 4'd0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      if (state == S_IDLE && any_req) begin
        gnt       <= win;
        last_gnt  <= win;
        lat_we    <= win ? bus.we1 : bus.we0;
        lat_addr  <= win ? bus.addr1[ADDR_WIDTH+1:2] : bus.addr0[ADDR_WIDTH+1:2];
        lat_wdata <= win ? bus.wdata1 : bus.wdata0;
      end
      if (state == S_ISSUE) begin
        cnt <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Capture on the edge that enters RESP; the other port keeps its word
      if (state_nxt == S_RESP) begin
        if (gnt) begin
          rdata1_q <= cap_data;
        end else begin
          rdata0_q <= cap_data;
        end
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.done0     = done0_c;
  assign bus.done1     = done1_c;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed vector bench for mem_arbiter at latencies 0, 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(10)) if0 (), if1 (), if3 ();

  mem_arbiter #(.ADDR_WIDTH(10), .MEM_LATENCY(0)) u_l0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mem_arbiter #(.ADDR_WIDTH(10), .MEM_LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(if1.slave));
  mem_arbiter #(.ADDR_WIDTH(10), .MEM_LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(if3.slave));

  // Memory models: write on the strobe edge, read data valid MEM_LATENCY cycles later
  logic [31:0] m0 [0:1023];
  logic [31:0] m1 [0:1023];
  logic [31:0] m3 [0:1023];
  logic [31:0] p1, p3a, p3b, p3c;

  assign if0.mem_rdata = m0[if0.mem_addr];
  assign if1.mem_rdata = p1;
  assign if3.mem_rdata = p3c;

  always @(posedge clk) begin
    if (if0.mem_en && if0.mem_we) m0[if0.mem_addr] <= if0.mem_wdata;
    if (if1.mem_en) p1 <= m1[if1.mem_addr];
    if (if1.mem_en && if1.mem_we) m1[if1.mem_addr] <= if1.mem_wdata;
    if (if3.mem_en) p3a <= m3[if3.mem_addr];
    if (if3.mem_en && if3.mem_we) m3[if3.mem_addr] <= if3.mem_wdata;
    p3b <= p3a;
    p3c <= p3b;
  end

  typedef struct {
    int          k;      // 0: latency 0, 1: latency 1, 2: latency 3
    int          p;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] maddr;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t        tv [14];
  logic [31:0] exp_rd [3][2];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cur   = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, cur, act, exp);
    end
  endtask

  task automatic set_port(input int k, input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    case (k)
      0:       if (p == 0) begin if0.req0 = r; if0.we0 = w; if0.addr0 = a; if0.wdata0 = d; end
               else        begin if0.req1 = r; if0.we1 = w; if0.addr1 = a; if0.wdata1 = d; end
      1:       if (p == 0) begin if1.req0 = r; if1.we0 = w; if1.addr0 = a; if1.wdata0 = d; end
               else        begin if1.req1 = r; if1.we1 = w; if1.addr1 = a; if1.wdata1 = d; end
      default: if (p == 0) begin if3.req0 = r; if3.we0 = w; if3.addr0 = a; if3.wdata0 = d; end
               else        begin if3.req1 = r; if3.we1 = w; if3.addr1 = a; if3.wdata1 = d; end
    endcase
  endtask

  function automatic logic [31:0] done_of(input int k, input int p);
    case (k)
      0:       return 32'((p == 0) ? if0.done0 : if0.done1);
      1:       return 32'((p == 0) ? if1.done0 : if1.done1);
      default: return 32'((p == 0) ? if3.done0 : if3.done1);
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int k, input int p);
    case (k)
      0:       return (p == 0) ? if0.rdata0 : if0.rdata1;
      1:       return (p == 0) ? if1.rdata0 : if1.rdata1;
      default: return (p == 0) ? if3.rdata0 : if3.rdata1;
    endcase
  endfunction

  // Packs {busy, mem_en, mem_we} so one accessor covers the status strobes
  function automatic logic [2:0] strb_of(input int k);
    case (k)
      0:       return {if0.busy, if0.mem_en, if0.mem_we};
      1:       return {if1.busy, if1.mem_en, if1.mem_we};
      default: return {if3.busy, if3.mem_en, if3.mem_we};
    endcase
  endfunction

  function automatic logic [31:0] maddr_of(input int k);
    case (k)
      0:       return 32'(if0.mem_addr);
      1:       return 32'(if1.mem_addr);
      default: return 32'(if3.mem_addr);
    endcase
  endfunction

  function automatic logic [31:0] mwdata_of(input int k);
    case (k)
      0:       return if0.mem_wdata;
      1:       return if1.mem_wdata;
      default: return if3.mem_wdata;
    endcase
  endfunction

  task automatic run_vec(input vec_t v);
    int          lat;
    int          stray;
    logic [31:0] got;
    logic [2:0]  s;
    lat   = -1;
    stray = 0;
    got   = 32'hdead_dead;
    set_port(v.k, v.p, 1'b1, v.we, v.addr, v.wdata);
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        s = strb_of(v.k);
        chk("issue_en", 32'(s[1]), 32'd1);
        chk("issue_we", 32'(s[0]), 32'(v.we));
        chk("issue_addr", maddr_of(v.k), v.maddr);
        if (v.we) chk("issue_wdata", mwdata_of(v.k), v.wdata);
      end
      if (done_of(v.k, 1 - v.p) != 32'd0) stray++;
      if (done_of(v.k, v.p) != 32'd0) begin
        lat = i;
        got = rdata_of(v.k, v.p);
        set_port(v.k, v.p, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    if (lat < 0) set_port(v.k, v.p, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("latency", 32'(lat), 32'(v.lat));
    chk("rdata", got, v.rdata);
    chk("other_done", 32'(stray), 32'd0);
    chk("other_rdata_held", rdata_of(v.k, 1 - v.p), exp_rd[v.k][1 - v.p]);
    @(negedge clk);
    s = strb_of(v.k);
    chk("idle_busy", 32'(s[2]), 32'd0);
    exp_rd[v.k][v.p] = v.rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order [6];
    int n_done, idle_run, bad_idle, both, multi, prev, stray;
    logic [2:0] s;

    for (int i = 0; i < 1024; i++) begin
      m0[i] = 32'h0; m1[i] = 32'h0; m3[i] = 32'h0;
    end
    m0[2] = 32'h003ff197; m1[2] = 32'h003ff197; m3[2] = 32'h003ff197;
    m1[3] = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      exp_rd[k][0] = 32'h0; exp_rd[k][1] = 32'h0;
      set_port(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_port(k, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    //         k  p  we    addr          wdata         maddr    lat rdata
    tv[0]  = '{1, 0, 1'b0, 32'h00000008, 32'h0,        32'd2,    3, 32'h003ff197};
    tv[1]  = '{1, 1, 1'b1, 32'h000000a0, 32'hbadab00f, 32'd40,   2, 32'h0};
    tv[2]  = '{1, 0, 1'b0, 32'h000000a0, 32'h0,        32'd40,   3, 32'hbadab00f};
    tv[3]  = '{1, 0, 1'b0, 32'h10000008, 32'h0,        32'd2,    3, 32'h003ff197};
    tv[4]  = '{1, 0, 1'b0, 32'h0000000b, 32'h0,        32'd2,    3, 32'h003ff197};
    tv[5]  = '{1, 1, 1'b0, 32'h0000000c, 32'h0,        32'd3,    3, 32'h12345678};
    tv[6]  = '{1, 0, 1'b1, 32'h00000ffc, 32'hcafef00d, 32'd1023, 2, 32'h0};
    tv[7]  = '{1, 1, 1'b0, 32'h00007ffc, 32'h0,        32'd1023, 3, 32'hcafef00d};
    tv[8]  = '{0, 0, 1'b0, 32'h00000008, 32'h0,        32'd2,    2, 32'h003ff197};
    tv[9]  = '{0, 1, 1'b1, 32'h00000040, 32'h0badf00d, 32'd16,   2, 32'h0};
    tv[10] = '{0, 0, 1'b0, 32'h00000040, 32'h0,        32'd16,   2, 32'h0badf00d};
    tv[11] = '{2, 0, 1'b0, 32'h00000008, 32'h0,        32'd2,    5, 32'h003ff197};
    tv[12] = '{2, 1, 1'b1, 32'h00000040, 32'h13579bdf, 32'd16,   2, 32'h0};
    tv[13] = '{2, 0, 1'b0, 32'h00000040, 32'h0,        32'd16,   5, 32'h13579bdf};

    // Reset state
    repeat (3) @(negedge clk);
    s = strb_of(1);
    chk("rst_busy_en_we", 32'(s), 32'd0);
    chk("rst_done", done_of(1, 0) | done_of(1, 1), 32'd0);
    chk("rst_rdata0", rdata_of(1, 0), 32'h0);
    chk("rst_rdata1", rdata_of(1, 1), 32'h0);
    chk("rst_mem_addr", maddr_of(1), 32'h0);
    chk("rst_mem_wdata", mwdata_of(1), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cur = i;
      run_vec(tv[i]);
    end

    // Reset while in WAIT: abort with no done pulse
    cur = 100;
    set_port(1, 0, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    @(negedge clk);
    s = strb_of(1);
    chk("wait_busy_en", 32'(s[2:1]), 32'b10);
    reset = 1'b1;
    set_port(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    s = strb_of(1);
    chk("abort_busy", 32'(s[2]), 32'd0);
    chk("abort_mem_en", 32'(s[1]), 32'd0);
    chk("abort_done", done_of(1, 0) | done_of(1, 1), 32'd0);
    reset = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if ((done_of(1, 0) | done_of(1, 1)) != 32'd0 || strb_of(1) != 3'b000) stray++;
    end
    chk("abort_quiet", 32'(stray), 32'd0);

    // Held tie for three rounds: core first, then strict alternation
    cur = 200;
    for (int r = 0; r < 6; r++) order[r] = -1;
    n_done = 0; idle_run = 0; bad_idle = 0; both = 0; multi = 0; prev = 0;
    set_port(1, 0, 1'b1, 1'b0, 32'h8, 32'h0);
    set_port(1, 1, 1'b1, 1'b0, 32'hc, 32'h0);
    for (int i = 0; i < 80 && n_done < 6; i++) begin
      @(negedge clk);
      if (done_of(1, 0) != 32'd0 && done_of(1, 1) != 32'd0) both++;
      if (strb_of(1)[2] == 1'b0) idle_run++;
      if ((done_of(1, 0) | done_of(1, 1)) != 32'd0) begin
        if (prev != 0) multi++;
        if (n_done > 0 && idle_run != 1) bad_idle++;
        order[n_done] = (done_of(1, 1) != 32'd0) ? 1 : 0;
        if (order[n_done] == 0) chk("tie_rdata0", rdata_of(1, 0), 32'h003ff197);
        else                    chk("tie_rdata1", rdata_of(1, 1), 32'h12345678);
        idle_run = 0;
        n_done++;
        prev = 1;
        if (n_done == 6) begin
          set_port(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
          set_port(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end else begin
        prev = 0;
      end
    end
    set_port(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("tie_done_count", 32'(n_done), 32'd6);
    for (int r = 0; r < 6; r++) chk("tie_order", 32'(order[r]), 32'(r % 2));
    chk("tie_both_done", 32'(both), 32'd0);
    chk("tie_multi_cycle_done", 32'(multi), 32'd0);
    chk("tie_idle_gap", 32'(bad_idle), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
